// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Purpose: FSM state encoding, default mult/div latency, the $0 register
// address and the interrupt vector address shared with the PC mux.
// Ports: none (package).
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN       = 1'b0,
    IRQ_ENTER = 1'b1
  } state_e;

  localparam int          MD_LAT_DEFAULT = 4;
  localparam logic [4:0]  REG_ZERO       = 5'd0;
  localparam logic [31:0] IRQ_VECTOR     = 32'h8000_0180;

endpackage

// File: rtl/md_busy_timer.sv
// rtl/md_busy_timer.sv - mult/div busy countdown timer
//
// Purpose: loads MD_LAT on md_start (including while already busy) and counts
// down to zero; busy is high while the count is nonzero.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous active-high reset, clears the count
//   md_start in  mult/div issued from EX this cycle
//   busy     out mult/div unit still busy
module md_busy_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  output logic busy
);

  logic [3:0] md_cnt_q;
  logic [3:0] md_cnt_d;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start) begin
      md_cnt_d = 4'(MD_LAT);
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q <= 4'd0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign busy = (md_cnt_q != 4'd0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush controller for the 5-stage pipeline
//
// Purpose: detects load-use, branch/jump and mult/div hazards, sequences
// interrupt entry and ERET return, and drives PC/pipeline-register enables,
// flushes, EPC capture and vector select.
// Optional build macro: HAZARD_PERF_EN adds 32-bit saturating performance
// counters perf_stall_cnt, perf_flush_cnt and perf_irq_cnt.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rt   source operands of the ID instruction
//   id_md_use                  ID instruction needs HI/LO or the mult/div unit
//   ex_memread, ex_rd          EX instruction is a load, and its destination
//   md_start                   mult/div issued from EX
//   branch_taken_ex, jump_id   control-flow redirects
//   eret_id, intterupt         exception return and interrupt request
//   pc_write, ifid_write       PC and IF/ID write enables
//   ifid/idex/exmem_flush      pipeline register clears
//   epc_capture, pc_vec_sel    interrupt entry controls
//   irq_masked                 handler active, interrupts ignored
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT,
  parameter int REG_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_md_use,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             md_start,
  input  logic             branch_taken_ex,
  input  logic             jump_id,
  input  logic             eret_id,
  input  logic             intterupt,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             epc_capture,
  output logic             pc_vec_sel,
  output logic             irq_masked
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt,
  output logic [31:0]      perf_irq_cnt
`endif
);

  state_e state_q;
  state_e state_d;
  logic   irq_masked_q;
  logic   irq_masked_d;

  logic md_busy;
  logic load_use;
  logic md_stall;
  logic stall;

  md_busy_timer #(
    .MD_LAT (MD_LAT)
  ) u_md_busy_timer (
    .clk      (clk),
    .reset    (reset),
    .md_start (md_start),
    .busy     (md_busy)
  );

  // $0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = ex_memread
                 && (ex_rd != REG_W'(REG_ZERO))
                 && ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  assign md_stall = md_busy && id_md_use;

  // A taken branch squashes the ID instruction, so its hazards do not stall.
  assign stall = !branch_taken_ex && (load_use || md_stall);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      irq_masked_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_masked_q <= irq_masked_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = RUN;
    irq_masked_d = irq_masked_q;
    case (state_q)
      RUN: begin
        // Branch redirect wins; a still-pending interrupt is taken next cycle.
        if (intterupt && !irq_masked_q && !branch_taken_ex) begin
          state_d = IRQ_ENTER;
        end
        // A stalled ERET stays in ID, so it is acted on once the stall releases.
        if (eret_id && !stall) begin
          irq_masked_d = 1'b0;
        end
      end
      IRQ_ENTER: begin
        state_d      = RUN;
        irq_masked_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Output logic
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    epc_capture = 1'b0;
    pc_vec_sel  = 1'b0;
    if (!reset) begin
      case (state_q)
        RUN: begin
          pc_write   = !stall;
          ifid_write = !stall;
          ifid_flush = branch_taken_ex || (jump_id && !stall);
          idex_flush = branch_taken_ex || stall;
        end
        IRQ_ENTER: begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          epc_capture = 1'b1;
          pc_vec_sel  = 1'b1;
        end
        default: begin
          pc_write = 1'b1;
        end
      endcase
    end
  end

  assign irq_masked = irq_masked_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;
  logic [31:0] perf_irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
      perf_irq_q   <= 32'd0;
    end else begin
      if (!pc_write && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (ifid_flush && (perf_flush_q != 32'hFFFF_FFFF)) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
      // IRQ_ENTER lasts exactly one cycle, so cycles equal entries.
      if ((state_q == IRQ_ENTER) && (perf_irq_q != 32'hFFFF_FFFF)) begin
        perf_irq_q <= perf_irq_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
  assign perf_irq_cnt   = perf_irq_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  // Output vector: {pc_write, ifid_write, ifid_flush, idex_flush,
  //                 exmem_flush, epc_capture, pc_vec_sel, irq_masked}
  localparam logic [7:0] O_RUN    = 8'hC0;
  localparam logic [7:0] O_RUN_M  = 8'hC1;
  localparam logic [7:0] O_STALL  = 8'h10;
  localparam logic [7:0] O_STL_M  = 8'h11;
  localparam logic [7:0] O_BRANCH = 8'hF0;
  localparam logic [7:0] O_JUMP   = 8'hE0;
  localparam logic [7:0] O_IRQ    = 8'hFE;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rt, id_md_use, ex_memread, md_start;
  logic       branch_taken_ex, jump_id, eret_id, intterupt;
  logic       pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
  logic       epc_capture, pc_vec_sel, irq_masked;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_irq_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .MD_LAT (4),
    .REG_W  (5)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_md_use       (id_md_use),
    .ex_memread      (ex_memread),
    .ex_rd           (ex_rd),
    .md_start        (md_start),
    .branch_taken_ex (branch_taken_ex),
    .jump_id         (jump_id),
    .eret_id         (eret_id),
    .intterupt       (intterupt),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .exmem_flush     (exmem_flush),
    .epc_capture     (epc_capture),
    .pc_vec_sel      (pc_vec_sel),
    .irq_masked      (irq_masked)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
    .perf_irq_cnt    (perf_irq_cnt)
`endif
  );

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_uses_rt = 1'b0; id_md_use = 1'b0; ex_memread = 1'b0; md_start = 1'b0;
    branch_taken_ex = 1'b0; jump_id = 1'b0; eret_id = 1'b0; intterupt = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    #1;
    obs = {pc_write, ifid_write, ifid_flush, idex_flush,
           exmem_flush, epc_capture, pc_vec_sel, irq_masked};
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_md_use = 1'b1;
    repeat (2) @(posedge clk);
    #2; chk("reset_forced", O_RUN);

    next_cycle(); reset = 1'b0; clear_inputs(); chk("idle", O_RUN);

    // Load-use via rs, one cycle only
    next_cycle(); ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; chk("lu_rs", O_STALL);
    next_cycle(); clear_inputs(); chk("lu_one_cycle", O_RUN);
    next_cycle(); ex_memread = 1'b1; chk("lu_r0", O_RUN);

    // Load-use via rt, gated by id_uses_rt
    next_cycle(); ex_memread = 1'b1; ex_rd = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b1;
    chk("lu_rt", O_STALL);
    next_cycle(); id_uses_rt = 1'b0; chk("lu_rt_unused", O_RUN);

    // Branch beats load-use; jump suppressed by stall; plain jump
    next_cycle(); id_rs = 5'd9; branch_taken_ex = 1'b1; chk("br_over_lu", O_BRANCH);
    next_cycle(); branch_taken_ex = 1'b0; jump_id = 1'b1; chk("jump_in_stall", O_STALL);
    next_cycle(); clear_inputs(); jump_id = 1'b1; chk("jump", O_JUMP);

    // Mult/div: start at cycle 0, stall cycles 1..4, free at 5
    next_cycle(); clear_inputs(); md_start = 1'b1; id_md_use = 1'b1; chk("md_c0", O_RUN);
    for (int i = 1; i <= 4; i++) begin
      next_cycle(); md_start = 1'b0; chk($sformatf("md_c%0d", i), O_STALL);
    end
    next_cycle(); chk("md_c5", O_RUN);

    // Restart at cycle 2 extends the stall through cycle 6
    next_cycle(); md_start = 1'b1; chk("md2_c0", O_RUN);
    next_cycle(); md_start = 1'b0; chk("md2_c1", O_STALL);
    next_cycle(); md_start = 1'b1; chk("md2_c2", O_STALL);
    for (int i = 3; i <= 6; i++) begin
      next_cycle(); md_start = 1'b0; chk($sformatf("md2_c%0d", i), O_STALL);
    end
    next_cycle(); chk("md2_c7", O_RUN);

    // Interrupt deferred by branch, then entered, then masked
    next_cycle(); clear_inputs(); intterupt = 1'b1; branch_taken_ex = 1'b1; chk("irq_br_first", O_BRANCH);
    next_cycle(); branch_taken_ex = 1'b0; chk("irq_pending", O_RUN);
    next_cycle(); chk("irq_enter", O_IRQ);
    next_cycle(); chk("irq_masked", O_RUN_M);
    next_cycle(); chk("irq_ignored", O_RUN_M);

    // ERET held during stall, then unmask and re-enter
    next_cycle(); eret_id = 1'b1; ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; chk("eret_stalled", O_STL_M);
    next_cycle(); ex_memread = 1'b0; ex_rd = 5'd0; id_rs = 5'd0; chk("eret_released", O_RUN_M);
    next_cycle(); eret_id = 1'b0; chk("unmasked", O_RUN);
    next_cycle(); chk("irq_reenter", O_IRQ);
    next_cycle(); intterupt = 1'b0; chk("remasked", O_RUN_M);

    // Reset while md_cnt=3 stall is active
    next_cycle(); clear_inputs(); md_start = 1'b1; id_md_use = 1'b1; chk("rst_md_start", O_RUN_M);
    next_cycle(); md_start = 1'b0; chk("rst_md_cnt4", O_STL_M);
    next_cycle(); reset = 1'b1; chk("reset_in_stall", O_RUN_M);
    next_cycle(); reset = 1'b0; chk("after_reset", O_RUN);
    next_cycle(); chk("after_reset2", O_RUN);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
